// File: rtl/ast_ctrl_pkg.sv
// Shared definitions for the ast pulse engine: command codes, FSM states and
// the layout of the stu_sensor status byte.
package ast_ctrl_pkg;

  typedef enum logic [7:0] {
    CMD_NONE  = 8'h00,
    CMD_FIRE  = 8'h01,
    CMD_ARM   = 8'h02,
    CMD_ABORT = 8'h03,
    CMD_CLR   = 8'h04
  } ast_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PULSE,
    ST_HOLDOFF
  } ast_state_e;

  typedef struct packed {
    logic [3:0] fire_cnt;
    logic       overrun;
    logic       edge_seen;
    logic       busy;
    logic       sensor_sync;
  } stu_sensor_t;

  // A programmed width of zero still produces a one-tick pulse.
  function automatic logic [7:0] eff_width(input logic [7:0] w);
    return (w == 8'd0) ? 8'd1 : w;
  endfunction

endpackage

// File: rtl/ast_ctrl_if.sv
// Register-block side of the ast pulse engine: command/config in, pulse and
// status out. The sensor pin travels with the bundle for convenience.
interface ast_ctrl_if;
  logic [7:0] cmd_ast;
  logic [7:0] cfg_pol;
  logic [7:0] cfg_width;
  logic       sensor_in;
  logic       ast_out;
  logic       busy;
  logic [7:0] stu_sensor;

  modport master (
    output cmd_ast, cfg_pol, cfg_width, sensor_in,
    input  ast_out, busy, stu_sensor
  );

  modport slave (
    input  cmd_ast, cfg_pol, cfg_width, sensor_in,
    output ast_out, busy, stu_sensor
  );
endinterface

// File: rtl/ast_ctrl_sync.sv
// Sensor synchroniser: SYNC_STAGES flop chain followed by a registered
// rising-edge detector producing a one-cycle strobe.
module ast_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic sensor_in,
  output logic sensor_lvl,
  output logic sensor_rise
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      chain_q     <= '0;
      prev_q      <= 1'b0;
      sensor_rise <= 1'b0;
    end else begin
      chain_q     <= {chain_q[SYNC_STAGES-2:0], sensor_in};
      prev_q      <= chain_q[SYNC_STAGES-1];
      sensor_rise <= chain_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign sensor_lvl = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/ast_ctrl.sv
// ast pulse engine: fires a timed pulse on FIRE or an armed sensor edge,
// enforces holdoff afterwards and reports sticky status for readback.
module ast_ctrl
  import ast_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50,
  parameter int unsigned HOLDOFF     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        clk_sys,
  input logic        rst_n,
  ast_ctrl_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLDOFF + 1);
  localparam int unsigned CW = (HW > 8) ? HW : 8;

  ast_state_e    state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [CW-1:0] cnt_q;
  logic          pol_q, pol_d, ast_q, ast_d, busy_q, busy_d;
  logic [3:0]    fire_cnt_q;
  logic          overrun_q, edge_seen_q;
  logic          sensor_lvl, sensor_rise;
  logic          is_fire, is_arm, is_abort, is_clr;
  logic          busy_st, tick, last_tick, entering, pulse_entry, ovr_set;
  logic          unused_pol_bits;
  stu_sensor_t   stu;

  ast_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .sensor_in   (bus.sensor_in),
    .sensor_lvl  (sensor_lvl),
    .sensor_rise (sensor_rise)
  );

  assign is_fire         = (bus.cmd_ast == CMD_FIRE);
  assign is_arm          = (bus.cmd_ast == CMD_ARM);
  assign is_abort        = (bus.cmd_ast == CMD_ABORT);
  assign is_clr          = (bus.cmd_ast == CMD_CLR);
  assign unused_pol_bits = ^bus.cfg_pol[7:1];

  assign busy_st   = (state_q == ST_PULSE) || (state_q == ST_HOLDOFF);
  assign tick      = busy_st && (presc_q == PW'(TICK_DIV - 1));
  assign last_tick = tick && (cnt_q == CW'(1));
  assign ovr_set   = busy_st && (is_fire || is_arm);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (is_fire)     state_d = ST_PULSE;
        else if (is_arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (is_abort)                    state_d = ST_IDLE;
        else if (sensor_rise || is_fire) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (is_abort)       state_d = ST_IDLE;
        else if (last_tick) state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (is_abort || last_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the pin moves on the same
  // edge that accepts the command; polarity freezes while busy.
  always_comb begin
    pol_d       = busy_st ? pol_q : bus.cfg_pol[0];
    ast_d       = (state_d == ST_PULSE) ? pol_d : ~pol_d;
    busy_d      = (state_d == ST_PULSE) || (state_d == ST_HOLDOFF);
    entering    = (state_d != state_q);
    pulse_entry = entering && (state_d == ST_PULSE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      pol_q       <= 1'b1;
      ast_q       <= 1'b0;
      busy_q      <= 1'b0;
      fire_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      edge_seen_q <= 1'b0;
    end else begin
      pol_q  <= pol_d;
      ast_q  <= ast_d;
      busy_q <= busy_d;
      if (entering) begin
        presc_q <= '0;
        cnt_q   <= (state_d == ST_PULSE) ? CW'(eff_width(bus.cfg_width)) : CW'(HOLDOFF);
      end else if (tick) begin
        presc_q <= '0;
        cnt_q   <= cnt_q - CW'(1);
      end else if (busy_st) begin
        presc_q <= presc_q + PW'(1);
      end
      // Setting events win over a CLR arriving in the same cycle.
      fire_cnt_q  <= (is_clr ? 4'd0 : fire_cnt_q) + {3'd0, pulse_entry};
      overrun_q   <= ovr_set | (overrun_q & ~is_clr);
      edge_seen_q <= sensor_rise | (edge_seen_q & ~is_clr);
    end
  end

  always_comb begin
    stu.fire_cnt    = fire_cnt_q;
    stu.overrun     = overrun_q;
    stu.edge_seen   = edge_seen_q;
    stu.busy        = busy_q;
    stu.sensor_sync = sensor_lvl;
  end

  assign bus.ast_out    = ast_q;
  assign bus.busy       = busy_q;
  assign bus.stu_sensor = stu;

endmodule

// File: tb/tb_ast_ctrl.sv
// Bench for ast_ctrl: stimulus schedules expected output snapshots for given
// cycles; a monitor compares the DUT against them on every falling edge.
module tb_ast_ctrl;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  ast_ctrl_if bus ();

  ast_ctrl #(.TICK_DIV(50), .HOLDOFF(4), .SYNC_STAGES(2)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // Observation vector: {ast_out, busy, fire_cnt[3:0], overrun, edge_seen, busy, sensor_sync}
  localparam logic [9:0] M_AST  = 10'h200;
  localparam logic [9:0] M_BUSY = 10'h100;
  localparam logic [9:0] M_CNT  = 10'h0F0;
  localparam logic [9:0] M_OVR  = 10'h008;
  localparam logic [9:0] M_EDGE = 10'h004;
  localparam logic [9:0] M_SS   = 10'h001;
  localparam logic [9:0] M_ALL  = 10'h3FF;

  typedef struct {
    int unsigned cyc;
    logic [9:0]  mask;
    logic [9:0]  val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    logic [9:0] obs;
    exp_t       keep[$];
    obs  = {bus.ast_out, bus.busy, bus.stu_sensor};
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if ((obs & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b want=%b mask=%b",
                   sb[i].name, cyc, obs & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask);
        end
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d got=unsampled want=sample_at_%0d", sb[i].name, cyc, sb[i].cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic expect_at(input int unsigned c, input logic [9:0] m,
                           input logic [9:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) tick(1);
  endtask

  task automatic send(input logic [7:0] c);
    bus.cmd_ast = c;
    tick(1);
    bus.cmd_ast = 8'h00;
  endtask

  initial begin
    int unsigned k, s, r, p, q;
    logic [9:0]  v;
    bus.cmd_ast   = 8'h00;
    bus.cfg_pol   = 8'h01;
    bus.cfg_width = 8'd3;
    bus.sensor_in = 1'b0;

    // Reset state
    tick(3);
    expect_at(cyc, M_ALL, 10'h000, "reset_hold");
    tick(1);
    rst_n = 1'b1;
    tick(2);
    expect_at(cyc, M_ALL, 10'h000, "reset_idle");

    // Default FIRE: width 3 -> 150 cycles active, 200 cycles holdoff
    k = cyc;
    expect_at(k,       M_AST | M_BUSY, 10'h000, "pre_fire");
    expect_at(k + 1,   M_AST | M_BUSY, 10'h300, "fire_start");
    expect_at(k + 150, M_AST | M_BUSY, 10'h300, "fire_last");
    expect_at(k + 151, M_AST | M_BUSY, 10'h100, "fire_end");
    expect_at(k + 350, M_BUSY,         10'h100, "holdoff_last");
    expect_at(k + 351, M_ALL,          10'h010, "idle_cnt1");
    send(8'h01);
    wait_until(k + 355);

    // Active-low, width 0 -> 50 cycles; polarity change frozen until idle
    bus.cfg_pol   = 8'hFE;
    bus.cfg_width = 8'd0;
    tick(2);
    expect_at(cyc, M_AST, 10'h200, "idle_pol0");
    k = cyc;
    expect_at(k + 1,   M_AST | M_BUSY,         10'h100, "pol0_start");
    expect_at(k + 40,  M_AST,                  10'h000, "pol_frozen");
    expect_at(k + 50,  M_AST | M_BUSY,         10'h100, "pol0_last");
    expect_at(k + 51,  M_AST | M_BUSY,         10'h300, "pol0_holdoff");
    expect_at(k + 250, M_AST | M_BUSY,         10'h300, "holdoff_old_pol");
    expect_at(k + 251, M_AST | M_BUSY,         10'h200, "idle_old_pol");
    expect_at(k + 252, M_AST | M_BUSY | M_CNT, 10'h020, "idle_new_pol");
    send(8'h01);
    wait_until(k + 20);
    bus.cfg_pol = 8'h01;
    wait_until(k + 255);
    bus.cfg_width = 8'd1;

    // ARM, sensor rise, then FIRE while busy and CLR during holdoff
    k = cyc;
    expect_at(k + 1, M_AST | M_BUSY, 10'h000, "armed_idle");
    send(8'h02);
    tick(3);
    s = cyc;
    bus.sensor_in = 1'b1;
    expect_at(s + 1,   M_SS,          10'h000, "sync_s1");
    expect_at(s + 2,   M_SS,          10'h001, "sync_s2");
    expect_at(s + 3,   M_AST | M_EDGE, 10'h000, "pre_rise");
    expect_at(s + 4,   M_ALL,         10'h337, "armed_fire");
    expect_at(s + 11,  M_AST | M_OVR, 10'h208, "overrun");
    expect_at(s + 53,  M_AST,         10'h200, "pulse_intact");
    expect_at(s + 54,  M_AST,         10'h000, "pulse_end");
    expect_at(s + 61,  M_ALL,         10'h103, "clr");
    expect_at(s + 253, M_BUSY,        10'h100, "holdoff_busy");
    expect_at(s + 254, M_BUSY,        10'h000, "holdoff_done");
    wait_until(s + 10);
    send(8'h01);
    wait_until(s + 60);
    send(8'h04);
    wait_until(s + 256);

    // Sensor rise coincident with CLR: edge_seen set wins
    bus.sensor_in = 1'b0;
    tick(6);
    r = cyc;
    bus.sensor_in = 1'b1;
    expect_at(r + 4, M_ALL, 10'h005, "edge_beats_clr");
    tick(3);
    send(8'h04);
    wait_until(r + 6);
    bus.sensor_in = 1'b0;
    send(8'h04);
    tick(2);

    // ABORT at cycle 20 of the pulse: idle immediately, no holdoff
    p = cyc;
    expect_at(p + 20, M_AST | M_BUSY, 10'h300, "pre_abort");
    expect_at(p + 21, M_ALL,          10'h010, "abort");
    expect_at(p + 25, M_BUSY,         10'h000, "no_holdoff");
    send(8'h01);
    wait_until(p + 20);
    send(8'h03);
    wait_until(p + 30);

    // 17 well-spaced FIREs: counter wraps 15 -> 0 -> 1
    send(8'h04);
    tick(1);
    for (int i = 1; i <= 17; i++) begin
      k = cyc;
      v = 10'(i % 16) << 4;
      expect_at(k + 1, M_CNT | M_OVR, v, "fire_cnt_wrap");
      send(8'h01);
      wait_until(k + 252);
    end

    // Asynchronous reset mid-pulse, then normal operation
    q = cyc;
    expect_at(q + 9, M_AST, 10'h200, "pre_reset");
    send(8'h01);
    wait_until(q + 10);
    rst_n = 1'b0;
    expect_at(cyc, M_ALL, 10'h000, "async_reset");
    tick(3);
    rst_n = 1'b1;
    tick(2);
    k = cyc;
    expect_at(k + 1,  M_AST | M_BUSY | M_CNT, 10'h310, "post_reset_fire");
    expect_at(k + 50, M_AST,                  10'h200, "post_reset_last");
    expect_at(k + 51, M_AST,                  10'h000, "post_reset_end");
    send(8'h01);
    wait_until(k + 55);

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
